// File: rtl/req_priority_arbiter.sv
// Grants one shared resource to N requesters, by fixed priority (highest index wins) or round-robin.
// The grant is registered, a dead cycle separates owners, and a hold limit forces release.
module req_priority_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             rr_en,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [IDX_W-1:0] gnt_idx_nxt;
  logic             gnt_vld_nxt;
  logic             timeout_nxt;

  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             grant_now;
  int               pos;

  // Winner search; in round-robin mode the nearest set bit after rr_ptr wins,
  // so the loop walks from farthest to nearest and the last hit is kept.
  always_comb begin
    win_idx = '0;
    win_any = |req;
    pos     = 0;
    if (!rr_en) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) win_idx = IDX_W'(i);
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        pos = (int'(rr_ptr) + k) % N;
        if (req[pos]) win_idx = IDX_W'(pos);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    rr_ptr_nxt   = rr_ptr;
    gnt_nxt      = gnt;
    gnt_idx_nxt  = gnt_idx;
    gnt_vld_nxt  = gnt_vld;
    timeout_nxt  = 1'b0;
    grant_now    = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) grant_now = 1'b1;
      end
      GRANT: begin
        if (done || !req[gnt_idx] || hold_cnt == HOLD_LAST) begin
          state_nxt   = GAP;
          gnt_nxt     = '0;
          gnt_vld_nxt = 1'b0;
          // Only the hold limit can be left once done and a dropped request are excluded.
          timeout_nxt = !done && req[gnt_idx];
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      GAP: begin
        if (win_any) grant_now = 1'b1;
        else         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (grant_now) begin
      state_nxt    = GRANT;
      gnt_nxt      = N'(1) << win_idx;
      gnt_idx_nxt  = win_idx;
      gnt_vld_nxt  = 1'b1;
      hold_cnt_nxt = '0;
      rr_ptr_nxt   = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rr_ptr   <= IDX_W'(N - 1);
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= gnt_idx_nxt;
      gnt_vld  <= gnt_vld_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule
